destruct_sequencer: RTL and testbench

FSM that sequences the self-destruct countdown. It sits between the debounced switch/"critical" logic and the LED driver, and replaces the free-running counter/dead pair with explicit arm, hold, abort and detonate phases. It runs on the main clock and advances only on a single-cycle 10 ms tick strobe.

---
 rtl/destruct_sequencer.sv | 153 +++++++++++++++
 tb/tb_destruct_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/destruct_sequencer.sv
// destruct_sequencer: tick-driven arm/countdown/hold/detonate FSM feeding the LED driver.
// Optional HOLD_BLINK_EN: blink the frozen seconds count on the LEDs while in HOLD.
module destruct_sequencer #(
    parameter int TICKS_PER_SEC = 100,
    parameter int COUNT_SECS    = 10,
    parameter int ARM_TICKS     = 30,
    parameter int HOLD_TICKS    = 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       in_combat,
    input  logic       critical,
    output logic [3:0] leds,
    output logic [2:0] state,
    output logic       counting,
    output logic       detonate
);
    localparam int SW = $clog2(TICKS_PER_SEC);
    localparam int AW = $clog2(ARM_TICKS + 1);
    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam logic [SW-1:0] SUB_LAST  = SW'(TICKS_PER_SEC - 1);
    localparam logic [3:0]    SEC_LAST  = 4'(COUNT_SECS - 1);
    localparam logic [AW-1:0] ARM_LAST  = AW'(ARM_TICKS - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARMING    = 3'd1,
        COUNTDOWN = 3'd2,
        HOLD      = 3'd3,
        DETONATED = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] arm_q, arm_d;
    logic [SW-1:0] sub_q, sub_d;
    logic [3:0]    sec_q, sec_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [3:0]    leds_q, leds_d;
    logic          counting_q, detonate_q;
`ifdef HOLD_BLINK_EN
    localparam logic [4:0] BLINK_LAST = 5'd24;
    logic [4:0] blink_q, blink_d;
    logic       show_q, show_d;
`endif

    always_comb begin
        state_d = state_q;
        arm_d   = arm_q;
        sub_d   = sub_q;
        sec_d   = sec_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (critical) state_d = ARMING;
            end
            ARMING: begin
                if (!critical) begin
                    state_d = IDLE;
                end else if (tick) begin
                    arm_d = arm_q + 1'b1;
                    if (arm_q == ARM_LAST) begin
                        state_d = COUNTDOWN;
                        sub_d   = '0;
                        sec_d   = '0;
                    end
                end
            end
            COUNTDOWN: begin
                // The final increment beats a simultaneous drop of critical
                if (tick && sub_q == SUB_LAST && sec_q == SEC_LAST) begin
                    state_d = DETONATED;
                    sub_d   = '0;
                    sec_d   = sec_q + 1'b1;
                end else if (!critical) begin
                    state_d = HOLD;
                    hold_d  = '0;
                end else if (tick) begin
                    sub_d = (sub_q == SUB_LAST) ? '0 : sub_q + 1'b1;
                    sec_d = (sub_q == SUB_LAST) ? sec_q + 1'b1 : sec_q;
                end
            end
            HOLD: begin
                if (critical) begin
                    state_d = COUNTDOWN;
                end else if (tick) begin
                    hold_d = hold_q + 1'b1;
                    if (hold_q == HOLD_LAST) state_d = IDLE;
                end
            end
            DETONATED: state_d = DETONATED;
            default:   state_d = IDLE;
        endcase
        if (!in_combat && state_q != DETONATED) state_d = IDLE;
        // Every path into IDLE starts the next attempt from scratch
        if (state_d == IDLE) begin
            arm_d  = '0;
            sub_d  = '0;
            sec_d  = '0;
            hold_d = '0;
        end
        leds_d = (state_d == DETONATED) ? 4'hF :
                 (state_d == COUNTDOWN || state_d == HOLD) ? sec_d : 4'h0;
`ifdef HOLD_BLINK_EN
        blink_d = blink_q;
        show_d  = show_q;
        if (state_d == HOLD && state_q != HOLD) begin
            blink_d = '0;
            show_d  = 1'b1;
        end else if (state_q == HOLD && tick) begin
            blink_d = (blink_q == BLINK_LAST) ? '0 : blink_q + 1'b1;
            show_d  = (blink_q == BLINK_LAST) ? !show_q : show_q;
        end
        if (state_d == HOLD && !show_d) leds_d = 4'h0;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            arm_q      <= '0;
            sub_q      <= '0;
            sec_q      <= '0;
            hold_q     <= '0;
            leds_q     <= '0;
            counting_q <= 1'b0;
            detonate_q <= 1'b0;
`ifdef HOLD_BLINK_EN
            blink_q    <= '0;
            show_q     <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            arm_q      <= arm_d;
            sub_q      <= sub_d;
            sec_q      <= sec_d;
            hold_q     <= hold_d;
            leds_q     <= leds_d;
            counting_q <= (state_d == COUNTDOWN);
            detonate_q <= (state_d == DETONATED);
`ifdef HOLD_BLINK_EN
            blink_q    <= blink_d;
            show_q     <= show_d;
`endif
        end
    end

    assign state    = state_q;
    assign leds     = leds_q;
    assign counting = counting_q;
    assign detonate = detonate_q;
endmodule

// File: tb/tb_destruct_sequencer.sv
// tb_destruct_sequencer: directed-vector bench for destruct_sequencer with default parameters.
module tb_destruct_sequencer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       in_combat = 1'b0;
    logic       critical = 1'b0;
    logic [3:0] leds;
    logic [2:0] state;
    logic       counting;
    logic       detonate;
    int         vectors = 0;
    int         errors = 0;

    destruct_sequencer dut (
        .clk(clk), .reset(reset), .tick(tick), .in_combat(in_combat), .critical(critical),
        .leds(leds), .state(state), .counting(counting), .detonate(detonate)
    );

    always #5 clk = ~clk;

    task automatic step(input logic t);
        tick = t;
        @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            step(1'b1);
            step(1'b0);
            step(1'b0);
            step(1'b0);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset state
        step(1'b0);
        step(1'b0);
        chk("rst_state", 32'(state), 0);
        chk("rst_leds", 32'(leds), 0);
        chk("rst_counting", 32'(counting), 0);
        chk("rst_detonate", 32'(detonate), 0);
        reset = 1'b0;
        // arm and count to detonation
        in_combat = 1'b1;
        critical = 1'b1;
        step(1'b0);
        chk("arming", 32'(state), 1);
        ticks(29);
        chk("arm_29", 32'(state), 1);
        ticks(1);
        chk("cd_enter", 32'(state), 2);
        chk("cd_counting", 32'(counting), 1);
        chk("cd_leds0", 32'(leds), 0);
        for (int s = 1; s <= 9; s++) begin
            ticks(100);
            chk("cd_sec", 32'(leds), 32'(s));
        end
        ticks(99);
        chk("cd_999", 32'(state), 2);
        ticks(1);
        chk("det_state", 32'(state), 4);
        chk("det_leds", 32'(leds), 32'hF);
        chk("det_flag", 32'(detonate), 1);
        chk("det_counting", 32'(counting), 0);
        // sticky against in_combat=0, cleared only by async reset
        in_combat = 1'b0;
        step(1'b0);
        step(1'b0);
        chk("sticky_state", 32'(state), 4);
        chk("sticky_flag", 32'(detonate), 1);
        reset = 1'b1;
        #1;
        chk("async_state", 32'(state), 0);
        chk("async_leds", 32'(leds), 0);
        chk("async_det", 32'(detonate), 0);
        reset = 1'b0;
        step(1'b0);
        // arming glitch
        in_combat = 1'b1;
        critical = 1'b1;
        step(1'b0);
        ticks(10);
        critical = 1'b0;
        step(1'b0);
        chk("glitch_idle", 32'(state), 0);
        chk("glitch_leds", 32'(leds), 0);
        ticks(40);
        chk("glitch_stay", 32'(state), 0);
        // hold and resume from 4/50
        critical = 1'b1;
        step(1'b0);
        ticks(30);
        ticks(450);
        chk("hr_pre", 32'(leds), 4);
        critical = 1'b0;
        step(1'b0);
        chk("hr_hold", 32'(state), 3);
        chk("hr_leds", 32'(leds), 4);
        chk("hr_counting", 32'(counting), 0);
        ticks(100);
        chk("hr_hold100", 32'(state), 3);
        chk("hr_frozen", 32'(leds), 4);
        critical = 1'b1;
        step(1'b0);
        chk("hr_resume", 32'(state), 2);
        ticks(549);
        chk("hr_549", 32'(state), 2);
        chk("hr_549_leds", 32'(leds), 9);
        ticks(1);
        chk("hr_det", 32'(state), 4);
        reset = 1'b1;
        step(1'b0);
        reset = 1'b0;
        // hold timeout and re-arm from zero
        step(1'b0);
        ticks(30);
        ticks(250);
        chk("to_pre", 32'(leds), 2);
        critical = 1'b0;
        step(1'b0);
        ticks(199);
        chk("to_199", 32'(state), 3);
        ticks(1);
        chk("to_idle", 32'(state), 0);
        chk("to_leds", 32'(leds), 0);
        critical = 1'b1;
        step(1'b0);
        ticks(30);
        chk("to_rearm", 32'(state), 2);
        ticks(100);
        chk("to_restart", 32'(leds), 1);
        // abort at sec 7, then re-arm
        ticks(600);
        chk("ab_pre", 32'(leds), 7);
        in_combat = 1'b0;
        step(1'b0);
        chk("ab_state", 32'(state), 0);
        chk("ab_leds", 32'(leds), 0);
        chk("ab_counting", 32'(counting), 0);
        in_combat = 1'b1;
        step(1'b0);
        ticks(30);
        ticks(100);
        chk("ab_restart", 32'(leds), 1);
        // critical drop on the final tick: detonation wins
        ticks(899);
        chk("fin_pre", 32'(leds), 9);
        critical = 1'b0;
        step(1'b1);
        chk("fin_det", 32'(state), 4);
        reset = 1'b1;
        step(1'b0);
        reset = 1'b0;
        // hold display at sec 3
        critical = 1'b1;
        step(1'b0);
        ticks(30);
        ticks(320);
        critical = 1'b0;
        step(1'b0);
        chk("bl_enter", 32'(leds), 3);
        ticks(25);
`ifdef HOLD_BLINK_EN
        chk("bl_off", 32'(leds), 0);
        ticks(25);
        chk("bl_on", 32'(leds), 3);
`else
        chk("bl_steady", 32'(leds), 3);
        ticks(25);
        chk("bl_steady2", 32'(leds), 3);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
